// File: rtl/fetch_ifid_if.sv
// Signal bundle between the fetch stage and its control/instruction-memory side.
// The master drives hazard controls, redirect and fetched data; the slave is the fetch stage.
interface fetch_ifid_if #(
  parameter int CNT_W = 16
);
  logic             in_pcwrite;
  logic             in_ifidwrite;
  logic             in_ifid_clear;
  logic             in_redirect;
  logic [31:0]      in_redirect_pc;
  logic [31:0]      in_instr;
  logic [31:0]      out_pc;
  logic [31:0]      out_ifid_pc;
  logic [31:0]      out_ifid_instr;
  logic             out_ifid_valid;
  logic [1:0]       out_state;
  logic [CNT_W-1:0] out_stall_cnt;
  logic [CNT_W-1:0] out_flush_cnt;
  logic             out_stall_timeout;

  modport master (
    output in_pcwrite, in_ifidwrite, in_ifid_clear, in_redirect, in_redirect_pc, in_instr,
    input  out_pc, out_ifid_pc, out_ifid_instr, out_ifid_valid, out_state,
           out_stall_cnt, out_flush_cnt, out_stall_timeout
  );

  modport slave (
    input  in_pcwrite, in_ifidwrite, in_ifid_clear, in_redirect, in_redirect_pc, in_instr,
    output out_pc, out_ifid_pc, out_ifid_instr, out_ifid_valid, out_state,
           out_stall_cnt, out_flush_cnt, out_stall_timeout
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Fetch stage: PC register, IF/ID register, redirect/stall/clear handling,
// saturating stall/flush event counters and a sticky consecutive-stall watchdog.
//
// state | meaning
// RUN   | last edge advanced the PC normally (or loaded a clear bubble)
// STALL | last edge held the PC because pcwrite was low
// FLUSH | last edge took a branch/JAL redirect and bubbled IF/ID
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_ifid_if.slave   bus
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_STALL);

  state_t           state_q, state_next;
  logic [31:0]      pc_q, pc_next;
  logic [31:0]      ifid_pc_q, ifid_pc_next;
  logic [31:0]      ifid_instr_q, ifid_instr_next;
  logic             ifid_valid_q, ifid_valid_next;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_next;
  logic [CNT_W-1:0] wd_q, wd_next;
  logic             timeout_q, timeout_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      wd_q         <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_next;
      pc_q         <= pc_next;
      ifid_pc_q    <= ifid_pc_next;
      ifid_instr_q <= ifid_instr_next;
      ifid_valid_q <= ifid_valid_next;
      stall_cnt_q  <= stall_cnt_next;
      flush_cnt_q  <= flush_cnt_next;
      wd_q         <= wd_next;
      timeout_q    <= timeout_next;
    end
  end

  always_comb begin
    state_next      = RUN;
    pc_next         = pc_q + 32'd4;
    ifid_pc_next    = ifid_pc_q;
    ifid_instr_next = ifid_instr_q;
    ifid_valid_next = ifid_valid_q;
    stall_cnt_next  = stall_cnt_q;
    flush_cnt_next  = flush_cnt_q;
    wd_next         = '0;

    if (bus.in_redirect) begin
      state_next      = FLUSH;
      pc_next         = {bus.in_redirect_pc[31:2], 2'b00};
      ifid_pc_next    = 32'h0;
      ifid_instr_next = NOP_INSTR;
      ifid_valid_next = 1'b0;
      if (flush_cnt_q != '1) flush_cnt_next = flush_cnt_q + 1'b1;
    end else if (!bus.in_pcwrite) begin
      state_next = STALL;
      pc_next    = pc_q;
      if (bus.in_ifidwrite) begin
        ifid_pc_next    = pc_q;
        ifid_instr_next = bus.in_instr;
        ifid_valid_next = 1'b1;
      end
      if (stall_cnt_q != '1) stall_cnt_next = stall_cnt_q + 1'b1;
      // Hold the watchdog at its limit so a very long stall cannot wrap it.
      wd_next = (wd_q == WD_LIMIT) ? wd_q : wd_q + 1'b1;
    end else if (bus.in_ifid_clear) begin
      ifid_pc_next    = 32'h0;
      ifid_instr_next = NOP_INSTR;
      ifid_valid_next = 1'b0;
    end else if (bus.in_ifidwrite) begin
      ifid_pc_next    = pc_q;
      ifid_instr_next = bus.in_instr;
      ifid_valid_next = 1'b1;
    end

    timeout_next = timeout_q | (wd_next == WD_LIMIT);
  end

  assign bus.out_pc            = pc_q;
  assign bus.out_ifid_pc       = ifid_pc_q;
  assign bus.out_ifid_instr    = ifid_instr_q;
  assign bus.out_ifid_valid    = ifid_valid_q;
  assign bus.out_state         = state_q;
  assign bus.out_stall_cnt     = stall_cnt_q;
  assign bus.out_flush_cnt     = flush_cnt_q;
  assign bus.out_stall_timeout = timeout_q;
endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed scenarios with literal checks plus a
// per-cycle comparison against a behavioural model of the fetch rules.
module tb_fetch_ifid_stage;
  localparam int          CNT_W     = 16;
  localparam int          MAX_STALL = 8;
  localparam logic [31:0] RST_PC    = 32'h0040_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fetch_ifid_if #(.CNT_W(CNT_W)) bus ();

  fetch_ifid_stage #(
    .RESET_PC(RST_PC), .NOP_INSTR(NOP), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: spec rules in plain procedural form.
  logic [31:0] m_pc, m_ifid_pc, m_ifid_instr;
  logic        m_valid, m_timeout;
  int          m_state, m_stalls, m_flushes, m_run;
  localparam int SAT = (1 << CNT_W) - 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RST_PC; m_ifid_pc = 0; m_ifid_instr = NOP; m_valid = 0;
      m_state = 0; m_stalls = 0; m_flushes = 0; m_run = 0; m_timeout = 0;
    end else if (bus.in_redirect) begin
      m_pc = bus.in_redirect_pc & 32'hFFFF_FFFC;
      m_ifid_pc = 0; m_ifid_instr = NOP; m_valid = 0;
      m_state = 2; m_run = 0;
      if (m_flushes < SAT) m_flushes++;
    end else if (!bus.in_pcwrite) begin
      if (bus.in_ifidwrite) begin
        m_ifid_pc = m_pc; m_ifid_instr = bus.in_instr; m_valid = 1;
      end
      m_state = 1; m_run++;
      if (m_stalls < SAT) m_stalls++;
      if (m_run >= MAX_STALL) m_timeout = 1;
    end else begin
      if (bus.in_ifid_clear) begin
        m_ifid_pc = 0; m_ifid_instr = NOP; m_valid = 0;
      end else if (bus.in_ifidwrite) begin
        m_ifid_pc = m_pc; m_ifid_instr = bus.in_instr; m_valid = 1;
      end
      m_pc = m_pc + 32'd4;
      m_state = 0; m_run = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_pc", bus.out_pc, m_pc);
      chk("m_ifid_pc", bus.out_ifid_pc, m_ifid_pc);
      chk("m_ifid_instr", bus.out_ifid_instr, m_ifid_instr);
      chk("m_ifid_valid", 32'(bus.out_ifid_valid), 32'(m_valid));
      chk("m_state", 32'(bus.out_state), 32'(m_state));
      chk("m_stall_cnt", 32'(bus.out_stall_cnt), 32'(m_stalls));
      chk("m_flush_cnt", 32'(bus.out_flush_cnt), 32'(m_flushes));
      chk("m_timeout", 32'(bus.out_stall_timeout), 32'(m_timeout));
    end
  end

  task automatic drive(input logic pw, input logic iw, input logic clr,
                       input logic rd, input logic [31:0] rpc);
    bus.in_pcwrite = pw; bus.in_ifidwrite = iw; bus.in_ifid_clear = clr;
    bus.in_redirect = rd; bus.in_redirect_pc = rpc;
  endtask

  // Apply the current inputs for n edges; return at the following negedge + 1.
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    drive(1, 1, 0, 0, 32'h0);
    bus.in_instr = 32'h0050_0093;
    #7;
    chk("rst_pc", bus.out_pc, RST_PC);
    chk("rst_ifid_instr", bus.out_ifid_instr, NOP);
    chk("rst_ifid_valid", 32'(bus.out_ifid_valid), 32'd0);
    chk("rst_state", 32'(bus.out_state), 32'd0);

    @(negedge clk); #1;
    rst_n = 1'b1;
    edges(1);
    chk("t1_pc1", bus.out_pc, 32'h0040_0004);
    chk("t1_ifid_pc", bus.out_ifid_pc, 32'h0040_0000);
    chk("t1_ifid_instr", bus.out_ifid_instr, 32'h0050_0093);
    chk("t1_ifid_valid", 32'(bus.out_ifid_valid), 32'd1);
    edges(1);
    chk("t1_pc2", bus.out_pc, 32'h0040_0008);

    drive(0, 0, 0, 0, 32'h0);
    edges(1);
    chk("t2_pc_hold", bus.out_pc, 32'h0040_0008);
    chk("t2_ifid_hold", bus.out_ifid_pc, 32'h0040_0004);
    chk("t2_state", 32'(bus.out_state), 32'd1);
    chk("t2_stall_cnt", 32'(bus.out_stall_cnt), 32'd1);
    drive(1, 1, 0, 0, 32'h0);
    edges(1);
    chk("t2_resume", bus.out_pc, 32'h0040_000C);

    drive(1, 1, 0, 1, 32'h0040_0103);
    edges(1);
    chk("t3_pc", bus.out_pc, 32'h0040_0100);
    chk("t3_valid", 32'(bus.out_ifid_valid), 32'd0);
    chk("t3_instr", bus.out_ifid_instr, NOP);
    chk("t3_state", 32'(bus.out_state), 32'd2);
    chk("t3_flush_cnt", 32'(bus.out_flush_cnt), 32'd1);

    drive(0, 0, 0, 1, 32'h0040_0200);
    edges(1);
    chk("t4_pc", bus.out_pc, 32'h0040_0200);
    chk("t4_stall_cnt", 32'(bus.out_stall_cnt), 32'd1);
    chk("t4_flush_cnt", 32'(bus.out_flush_cnt), 32'd2);

    drive(1, 1, 1, 0, 32'h0);
    edges(1);
    chk("clr_pc", bus.out_pc, 32'h0040_0204);
    chk("clr_valid", 32'(bus.out_ifid_valid), 32'd0);
    chk("clr_state", 32'(bus.out_state), 32'd0);

    // Stall with ifidwrite=1 reloads IF/ID with the held PC.
    bus.in_instr = 32'h0020_8133;
    drive(0, 1, 0, 0, 32'h0);
    edges(7);
    chk("wd7_pc", bus.out_pc, 32'h0040_0204);
    chk("wd7_ifid_pc", bus.out_ifid_pc, 32'h0040_0204);
    chk("wd7_timeout", 32'(bus.out_stall_timeout), 32'd0);
    drive(1, 1, 0, 0, 32'h0);
    edges(1);
    drive(0, 0, 0, 0, 32'h0);
    edges(7);
    chk("wd77_timeout", 32'(bus.out_stall_timeout), 32'd0);
    drive(1, 1, 0, 0, 32'h0);
    edges(1);
    drive(0, 0, 0, 0, 32'h0);
    edges(7);
    chk("wd8_pre", 32'(bus.out_stall_timeout), 32'd0);
    edges(1);
    chk("wd8_trip", 32'(bus.out_stall_timeout), 32'd1);
    drive(1, 1, 0, 0, 32'h0);
    edges(2);
    chk("wd8_sticky", 32'(bus.out_stall_timeout), 32'd1);

    drive(1, 1, 0, 1, 32'hFFFF_FFFF);
    edges(1);
    chk("wrap_pre", bus.out_pc, 32'hFFFF_FFFC);
    drive(1, 1, 0, 0, 32'h0);
    edges(1);
    chk("wrap_pc", bus.out_pc, 32'h0000_0000);
    chk("wrap_ifid_pc", bus.out_ifid_pc, 32'hFFFF_FFFC);

    // Stall count so far: 1+7+7+8 = 23; run past saturation.
    drive(0, 0, 0, 0, 32'h0);
    edges(SAT - 23 + 5);
    chk("sat_stall_cnt", 32'(bus.out_stall_cnt), 32'h0000_FFFF);

    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pc", bus.out_pc, RST_PC);
    chk("ar_ifid_pc", bus.out_ifid_pc, 32'h0);
    chk("ar_state", 32'(bus.out_state), 32'd0);
    chk("ar_stall_cnt", 32'(bus.out_stall_cnt), 32'd0);
    chk("ar_flush_cnt", 32'(bus.out_flush_cnt), 32'd0);
    chk("ar_timeout", 32'(bus.out_stall_timeout), 32'd0);
    chk("ar_valid", 32'(bus.out_ifid_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
